// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
// Build option: RAM_ARB_FIXED_PRIO_EN selects fixed priority (port 0 wins).
package ram_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic PORT_LSU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

endpackage

// File: rtl/ram_port_arbiter_rr_arb2.sv
// Combinational 2-way picker: round-robin by default,
// fixed priority (port 0) when RAM_ARB_FIXED_PRIO_EN is defined.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic [1:0] req,
`ifndef RAM_ARB_FIXED_PRIO_EN
  input  logic       last_grant,
`endif
  output logic       grant
);

  always_comb begin
    grant = PORT_LSU;
`ifdef RAM_ARB_FIXED_PRIO_EN
    if (!req[0] && req[1]) grant = PORT_DMA;
`else
    // on contention the port that did not go last wins
    if (req == 2'b11) grant = ~last_grant;
    else if (req[1]) grant = PORT_DMA;
`endif
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates one single-port RAM between the LSU and DMA requesters.
// Build option: RAM_ARB_FIXED_PRIO_EN drops round-robin state.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              wr0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  input  logic              req1,
  input  logic              wr1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata,
  output logic [DATA_W-1:0] ram_data,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_q,
  output logic              busy
);

  state_t     state;
  state_t     state_n;
  logic       grant;
  logic       pick;
  logic       any_req;
  logic [1:0] reqs;

  assign reqs    = {req1, req0};
  assign any_req = |reqs;

`ifdef RAM_ARB_FIXED_PRIO_EN
  rr_arb2 u_arb (
    .req   (reqs),
    .grant (pick)
  );
`else
  logic last_grant;

  rr_arb2 u_arb (
    .req        (reqs),
    .last_grant (last_grant),
    .grant      (pick)
  );

  // reset to DMA so the LSU wins the first contention
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= PORT_DMA;
    end else if (state == DONE) begin
      last_grant <= grant;
    end
  end
`endif

  always_comb begin
    state_n = state;
    ram_en  = 1'b0;
    busy    = 1'b1;
    ack0    = 1'b0;
    ack1    = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (any_req) state_n = ACCESS;
      end
      ACCESS: begin
        ram_en  = 1'b1;
        state_n = DONE;
      end
      DONE: begin
        ack0    = (grant == PORT_LSU);
        ack1    = (grant == PORT_DMA);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      grant    <= PORT_LSU;
      ram_wr   <= 1'b0;
      ram_addr <= '0;
      ram_data <= '0;
      rdata    <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && any_req) begin
        grant    <= pick;
        ram_wr   <= (pick == PORT_DMA) ? wr1 : wr0;
        ram_addr <= (pick == PORT_DMA) ? addr1 : addr0;
        ram_data <= (pick == PORT_DMA) ? wdata1 : wdata0;
      end
      if (state == ACCESS && !ram_wr) begin
        rdata <= ram_q;
      end
    end
  end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter with a transaction-level model.
// Build option: RAM_ARB_FIXED_PRIO_EN switches the contention scenario.
module tb_ram_port_arbiter;
  import ram_arb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_clr;
  logic          run_cmp;
  logic          req   [2];
  logic          wr    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          ack0, ack1;
  logic [DW-1:0] rdata, ram_data, ram_q;
  logic [AW-1:0] ram_addr;
  logic          ram_wr, ram_en, busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req0     (req[0]),
    .wr0      (wr[0]),
    .addr0    (addr[0]),
    .wdata0   (wdata[0]),
    .ack0     (ack0),
    .req1     (req[1]),
    .wr1      (wr[1]),
    .addr1    (addr[1]),
    .wdata1   (wdata[1]),
    .ack1     (ack1),
    .rdata    (rdata),
    .ram_data (ram_data),
    .ram_addr (ram_addr),
    .ram_wr   (ram_wr),
    .ram_en   (ram_en),
    .ram_q    (ram_q),
    .busy     (busy)
  );

  // RAM instance the arbiter drives
  logic [DW-1:0] mem [32];
  assign ram_q = mem[ram_addr];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (ram_en && ram_wr) begin
      mem[ram_addr] <= ram_data;
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: a granted request occupies the RAM for the
  // next cycle and completes (ack) in the cycle after that.
  int            m_left;
  int            m_port;
  logic          m_last;
  logic          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [DW-1:0] m_rdata;
  logic [DW-1:0] refmem [32];

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 32; i++) refmem[i] = '0;
    end
    if (rst) begin
      m_left  = 0;
      m_port  = 0;
      m_last  = 1'b1;
      m_wr    = 1'b0;
      m_addr  = '0;
      m_data  = '0;
      m_rdata = '0;
    end else if (m_left == 0) begin
      if (req[0] || req[1]) begin
        if (req[0] && req[1]) begin
`ifdef RAM_ARB_FIXED_PRIO_EN
          m_port = 0;
`else
          m_port = (m_last == 1'b0) ? 1 : 0;
`endif
        end else begin
          m_port = req[1] ? 1 : 0;
        end
        m_wr   = wr[m_port];
        m_addr = addr[m_port];
        m_data = wdata[m_port];
        m_left = 2;
      end
    end else if (m_left == 2) begin
      if (m_wr) refmem[m_addr] = m_data;
      else m_rdata = refmem[m_addr];
      m_left = 1;
    end else begin
      m_last = (m_port == 1);
      m_left = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst && run_cmp) begin
      chk("ram_en", ram_en, m_left == 2);
      chk("busy", busy, m_left != 0);
      chk("ack0", ack0, m_left == 1 && m_port == 0);
      chk("ack1", ack1, m_left == 1 && m_port == 1);
      chk("ram_wr", ram_wr, m_wr);
      chk("ram_addr", ram_addr, m_addr);
      chk("ram_data", ram_data, m_data);
      chk("rdata", rdata, m_rdata);
    end
  end

  logic          acc_en, acc_wr;
  logic [AW-1:0] acc_addr;

  task automatic do_op(input int p, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, output logic [DW-1:0] rd,
                       output int lat, output time tack);
    req[p]   = 1'b1;
    wr[p]    = w;
    addr[p]  = a;
    wdata[p] = d;
    lat  = 0;
    tack = 0;
    rd   = '0;
    for (int k = 1; k <= 50; k++) begin
      @(negedge clk);
      if (k == 2) begin
        acc_en   = ram_en;
        acc_wr   = ram_wr;
        acc_addr = ram_addr;
      end
      if ((p == 0) ? ack0 : ack1) begin
        lat = k;
        break;
      end
    end
    if (lat == 0) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout: port %0d got no ack, expected one", p);
    end else begin
      rd   = rdata;
      tack = $time;
    end
    @(posedge clk);
    #1;
    req[p] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  logic [DW-1:0] rd0, rd1;
  int            lat0, lat1;
  time           t0a, t0b, t1, tprev;

  initial begin
    rst     = 1'b1;
    mem_clr = 1'b1;
    run_cmp = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i]   = 1'b0;
      wr[i]    = 1'b0;
      addr[i]  = '0;
      wdata[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack0", ack0, 0);
    chk("rst_ack1", ack1, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_wr", ram_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    chk("rst_rdata", rdata, 0);
    rst     = 1'b0;
    mem_clr = 1'b0;
    run_cmp = 1'b1;

    // single write then read on port 0
    do_op(0, 1'b1, 5'd5, 32'hDEADBEEF, rd0, lat0, t0a);
    chk("wr_latency", lat0, 3);
    chk("wr_acc_en", acc_en, 1);
    chk("wr_acc_wr", acc_wr, 1);
    chk("wr_acc_addr", acc_addr, 5);
    do_op(0, 1'b0, 5'd5, 32'h0, rd0, lat0, t0a);
    chk("rd_latency", lat0, 3);
    chk("rd_data", rd0, 32'hDEADBEEF);

`ifndef RAM_ARB_FIXED_PRIO_EN
    // contention from reset: 0, 1, then 0 again after re-issue
    pulse_reset();
    fork
      begin
        do_op(0, 1'b1, 5'd10, 32'hAAAA0000, rd0, lat0, t0a);
        do_op(0, 1'b1, 5'd11, 32'hAAAA0001, rd0, lat0, t0b);
      end
      do_op(1, 1'b1, 5'd12, 32'hBBBB0000, rd1, lat1, t1);
    join
    chk("rr_first_p0", t1 - t0a, 30);
    chk("rr_then_p0", t0b - t1, 30);

    // same address: last grant was port 0, so the DMA write goes first
    fork
      do_op(1, 1'b1, 5'd31, 32'h12345678, rd1, lat1, t1);
      do_op(0, 1'b0, 5'd31, 32'h0, rd0, lat0, t0a);
    join
    chk("same_addr_order", t0a - t1, 30);
    chk("same_addr_data", rd0, 32'h12345678);
`endif

    // reset during the ACCESS cycle of a write
    @(posedge clk);
    #1;
    req[0]   = 1'b1;
    wr[0]    = 1'b1;
    addr[0]  = 5'd3;
    wdata[0] = 32'hFFFFFFFF;
    @(posedge clk);
    #2;
    chk("abort_en_before", ram_en, 1);
    #1 rst = 1'b1;
    #1;
    chk("abort_en_drop", ram_en, 0);
    chk("abort_busy", busy, 0);
    req[0] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("abort_no_ack", ack0, 0);
    end
    @(posedge clk);
    #1;
    do_op(0, 1'b0, 5'd3, 32'h0, rd0, lat0, t0a);
    chk("abort_ram_kept", rd0, 0);

    // back-to-back: fill then read addrs 0..7
    for (int i = 0; i < 8; i++) begin
      do_op(0, 1'b1, AW'(i), 32'hC0DE0000 + i, rd0, lat0, t0a);
    end
    for (int i = 0; i < 8; i++) begin
      do_op(0, 1'b0, AW'(i), 32'h0, rd0, lat0, t0a);
      chk("b2b_latency", lat0, 3);
      chk("b2b_data", rd0, 32'hC0DE0000 + i);
      if (i > 0) chk("b2b_spacing", t0a - tprev, 30);
      tprev = t0a;
    end
    @(negedge clk);
    chk("b2b_busy_end", busy, 0);

`ifdef RAM_ARB_FIXED_PRIO_EN
    // port 0 continuous traffic starves port 1 until it stops
    pulse_reset();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          do_op(0, 1'b0, AW'(i), 32'h0, rd0, lat0, t0a);
        end
      end
      do_op(1, 1'b0, 5'd7, 32'h0, rd1, lat1, t1);
    join
    chk("fixed_p1_after", t1 - t0a, 30);
    chk("fixed_p1_data", rd1, 32'hC0DE0007);
`endif

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
